multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle variant of the 64-bit RV64 datapath. It breaks each instruction into fetch, decode, execute, memory and write-back steps. It drives the enable and mux-select strobes for the shared ALU, the single memory port, the IR/OldPC registers, the register file and the PC. It also keeps cycle/retired-instruction counters and a sticky illegal-opcode trap.

## Interface
Parameters:
- CNT_W, 64, width of cycle_count and instret_count

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears counters/trap
- run  in  1  level; while 1, FSM leaves IDLE and keeps executing
- opcode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU Zero flag, sampled combinationally in BRANCH
- pc_write  out  1  PC load enable, already qualified with zero
- old_pc_write  out  1  latch current PC into OldPC
- ir_write  out  1  load memory read data into IR
- mem_read  out  1  memory port read strobe
- mem_write  out  1  memory port write strobe
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 PC, 01 reg A (rs1), 10 OldPC
- alu_src_b  out  2  00 reg B, 01 const 4, 10 imm, 11 imm<<1
- alu_op  out  2  00 add, 01 subtract (compare), 10 funct-decoded
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- halted  out  1  1 in IDLE or TRAP
- illegal_op  out  1  sticky; 1 in TRAP
- cycle_count  out  CNT_W  cycles spent outside IDLE/TRAP
- instret_count  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, TRAP.
- Strobe encoding per state. Any output not listed is 0; selects not listed are 0.
  - IDLE: all strobes 0. Goes to FETCH when run = 1.
  - FETCH: mem_read = 1, i_or_d = 0, ir_write = 1, old_pc_write = 1, alu_src_a = 00, alu_src_b = 01, alu_op = 00, pc_source = 0, pc_write = 1.
  - DECODE: alu_src_a = 10, alu_src_b = 11, alu_op = 00. Computes the branch target into ALUOut.
- DECODE next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP
- Execute/memory states:
  - EXEC_R: alu_src_a = 01, alu_src_b = 00, alu_op = 10. Next ALU_WB.
  - EXEC_I: alu_src_a = 01, alu_src_b = 10, alu_op = 10. Next ALU_WB.
  - ALU_WB: reg_write = 1, mem_to_reg = 0. Retires.
  - MEM_ADDR: alu_src_a = 01, alu_src_b = 10, alu_op = 00. Next MEM_RD if opcode = 0000011, else MEM_WR.
  - MEM_RD: mem_read = 1, i_or_d = 1. Next MEM_WB.
  - MEM_WB: reg_write = 1, mem_to_reg = 1. Retires.
  - MEM_WR: mem_write = 1, i_or_d = 1. Retires.
  - BRANCH: alu_src_a = 01, alu_src_b = 00, alu_op = 01, pc_source = 1, pc_write = zero. Retires.
- Retire: instret_count += 1, then next state is FETCH if run = 1, else IDLE. An instruction already started always completes, even if run drops mid-instruction.
- TRAP: illegal_op = 1, halted = 1, all strobes 0. Exits only on reset; run is ignored.
- cycle_count increments on every clock whose current state is not IDLE or TRAP. Both counters wrap modulo 2^CNT_W with no saturation.
- mem_read and mem_write are never 1 in the same cycle. reg_write and pc_write are never 1 in the same cycle.

## Timing
- Outputs are Moore decodes of the registered state. The only exception is pc_write in BRANCH, which combinationally follows zero.
- Reset values (asynchronous): state = IDLE, halted = 1, illegal_op = 0, both counters = 0, all strobes 0.
- Reset asserted mid-instruction aborts it immediately. The instruction is not counted, and any strobe in progress drops within the same cycle.
- Cycles per instruction, from FETCH to the next FETCH:
  - beq: 3
  - R-type: 4
  - I-type: 4
  - sd: 4
  - ld: 5
- Latency from run rising in IDLE to FETCH: 1 clock.
- Counter outputs are registered. A retire in cycle N is visible on instret_count in cycle N+1.

## Test plan
- Reset held, run = 1 → state IDLE, halted = 1, all strobes 0, counters 0. Release reset → FETCH on the next edge with mem_read = ir_write = pc_write = 1.
- run = 1, opcode = 0110011 → FETCH, DECODE, EXEC_R, ALU_WB, FETCH. reg_write = 1 only in cycle 4. After one instruction, instret_count = 1 and cycle_count = 4.
- opcode = 0000011 then 0100011 back to back → 5-cycle ld followed by 4-cycle sd, each memory strobe asserted for exactly one cycle with i_or_d = 1. Final instret_count = 2 and cycle_count = 9.
- opcode = 1100011 with zero = 0, then with zero = 1 → pc_write stays 0 in the first BRANCH and is 1 in the second, with pc_source = 1. CPI is 3 both times.
- opcode = 1111111 → DECODE goes to TRAP, illegal_op = 1, halted = 1, counters frozen, and toggling run has no effect. Only reset clears it.
- run dropped during EXEC_I → ALU_WB still completes with reg_write = 1, then the FSM goes to IDLE. Reset asserted in MEM_RD → IDLE within the same cycle, mem_read drops, instret_count unchanged.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM and the RV64 datapath:
// opcode/zero flow up from the datapath, enable and select strobes flow down.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;

    modport master (
        input  opcode, zero,
        output pc_write, old_pc_write, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );

    modport slave (
        output opcode, zero,
        input  pc_write, old_pc_write, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV64 main control FSM: Moore strobe decode per step, cycle and
// retired-instruction counters, and a sticky illegal-opcode trap.
module multicycle_control #(
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    multicycle_control_if.master bus,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instret_count
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_REG   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMM2  = 2'b11;
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH,
        TRAP
    } state_t;

    state_t state, next_state;
    logic   retire;
    logic   active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Retiring states pick the follow-on step from run; anything mid-flight
    // ignores run so a started instruction always completes.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        unique case (state)
            IDLE:     if (run) next_state = FETCH;
            FETCH:    next_state = DECODE;
            DECODE: begin
                unique case (bus.opcode)
                    OP_R:          next_state = EXEC_R;
                    OP_I:          next_state = EXEC_I;
                    OP_LD, OP_SD:  next_state = MEM_ADDR;
                    OP_BRNCH:      next_state = BRANCH;
                    default:       next_state = TRAP;
                endcase
            end
            EXEC_R:   next_state = ALU_WB;
            EXEC_I:   next_state = ALU_WB;
            MEM_ADDR: next_state = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   next_state = MEM_WB;
            MEM_WB, MEM_WR, ALU_WB, BRANCH: begin
                retire     = 1'b1;
                next_state = run ? FETCH : IDLE;
            end
            TRAP:     next_state = TRAP;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.pc_write     = 1'b0;
        bus.old_pc_write = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.alu_src_a    = SRC_A_PC;
        bus.alu_src_b    = SRC_B_REG;
        bus.alu_op       = ALU_ADD;
        bus.pc_source    = 1'b0;
        halted           = 1'b0;
        illegal_op       = 1'b0;
        unique case (state)
            IDLE: halted = 1'b1;
            FETCH: begin
                bus.mem_read     = 1'b1;
                bus.ir_write     = 1'b1;
                bus.old_pc_write = 1'b1;
                bus.alu_src_a    = SRC_A_PC;
                bus.alu_src_b    = SRC_B_FOUR;
                bus.alu_op       = ALU_ADD;
                bus.pc_write     = 1'b1;
            end
            DECODE: begin
                bus.alu_src_a = SRC_A_OLDPC;
                bus.alu_src_b = SRC_B_IMM2;
                bus.alu_op    = ALU_ADD;
            end
            EXEC_R: begin
                bus.alu_src_a = SRC_A_REG;
                bus.alu_src_b = SRC_B_REG;
                bus.alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                bus.alu_src_a = SRC_A_REG;
                bus.alu_src_b = SRC_B_IMM;
                bus.alu_op    = ALU_FUNCT;
            end
            MEM_ADDR: begin
                bus.alu_src_a = SRC_A_REG;
                bus.alu_src_b = SRC_B_IMM;
                bus.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            ALU_WB: bus.reg_write = 1'b1;
            // Only combinational path through the block: branch taken on zero.
            BRANCH: begin
                bus.alu_src_a = SRC_A_REG;
                bus.alu_src_b = SRC_B_REG;
                bus.alu_op    = ALU_SUB;
                bus.pc_source = 1'b1;
                bus.pc_write  = bus.zero;
            end
            TRAP: begin
                halted     = 1'b1;
                illegal_op = 1'b1;
            end
            default: halted = 1'b1;
        endcase
    end

    assign active = (state != IDLE) && (state != TRAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (active) cycle_count   <= cycle_count + 1'b1;
            if (retire) instret_count <= instret_count + 1'b1;
        end
    end

    a_mem_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_read && bus.mem_write));
    a_wr_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.reg_write && bus.pc_write));
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes per-cycle expected
// strobes/counters into a scoreboard, a negedge monitor pops and compares.
module tb_multicycle_control;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef enum {T_IDLE, T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_MEM_ADDR,
                  T_MEM_RD, T_MEM_WB, T_MEM_WR, T_ALU_WB, T_BRANCH, T_TRAP} tst_t;

    typedef struct packed {
        logic       pcw, opw, irw, mr, mw, iod, rw, m2r;
        logic [1:0] a, b, op;
        logic       pcs, hlt, ill;
    } sig_t;

    typedef struct {
        string       name;
        sig_t        sig;
        logic [63:0] cyc;
        logic [63:0] ret;
    } exp_t;

    logic clk, reset, run;
    logic halted, illegal_op;
    logic [63:0] cycle_count, instret_count;
    multicycle_control_if bus();

    multicycle_control #(.CNT_W(64)) dut (
        .clk(clk), .reset(reset), .run(run), .bus(bus),
        .halted(halted), .illegal_op(illegal_op),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          idx = 0;
    logic [63:0] ecyc = '0;
    logic [63:0] eret = '0;

    // Strobe table written straight from the state encoding description.
    function automatic sig_t sig_of(tst_t t, logic z);
        sig_t s = '0;
        case (t)
            T_IDLE:     s.hlt = 1'b1;
            T_FETCH:    begin s.mr = 1; s.irw = 1; s.opw = 1; s.pcw = 1; s.b = 2'b01; end
            T_DECODE:   begin s.a = 2'b10; s.b = 2'b11; end
            T_EXEC_R:   begin s.a = 2'b01; s.b = 2'b00; s.op = 2'b10; end
            T_EXEC_I:   begin s.a = 2'b01; s.b = 2'b10; s.op = 2'b10; end
            T_MEM_ADDR: begin s.a = 2'b01; s.b = 2'b10; end
            T_MEM_RD:   begin s.mr = 1; s.iod = 1; end
            T_MEM_WB:   begin s.rw = 1; s.m2r = 1; end
            T_MEM_WR:   begin s.mw = 1; s.iod = 1; end
            T_ALU_WB:   s.rw = 1'b1;
            T_BRANCH:   begin s.a = 2'b01; s.op = 2'b01; s.pcs = 1; s.pcw = z; end
            T_TRAP:     begin s.hlt = 1; s.ill = 1; end
            default:    s = '0;
        endcase
        return s;
    endfunction

    // One clock of stimulus: t is the hand-sequenced state expected in this
    // cycle; inputs are applied 1ns after the rising edge.
    task automatic cyc(tst_t t, logic r, logic rn, logic [6:0] op, logic z);
        exp_t e;
        reset      = r;
        run        = rn;
        bus.opcode = op;
        bus.zero   = z;
        if (r) begin ecyc = '0; eret = '0; end
        e.name = $sformatf("%s@%0d", t.name(), idx);
        e.sig  = sig_of(t, z);
        e.cyc  = ecyc;
        e.ret  = eret;
        sb.push_back(e);
        idx++;
        if (!r && t != T_IDLE && t != T_TRAP) ecyc++;
        if (!r && (t == T_ALU_WB || t == T_MEM_WB || t == T_MEM_WR || t == T_BRANCH)) eret++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            sig_t act;
            e = sb.pop_front();
            act = '{pcw: bus.pc_write, opw: bus.old_pc_write, irw: bus.ir_write,
                    mr: bus.mem_read, mw: bus.mem_write, iod: bus.i_or_d,
                    rw: bus.reg_write, m2r: bus.mem_to_reg, a: bus.alu_src_a,
                    b: bus.alu_src_b, op: bus.alu_op, pcs: bus.pc_source,
                    hlt: halted, ill: illegal_op};
            n_chk++;
            if (act !== e.sig) begin
                n_fail++;
                $display("FAIL %s strobes got=%b exp=%b", e.name, act, e.sig);
            end
            n_chk++;
            if (cycle_count !== e.cyc) begin
                n_fail++;
                $display("FAIL %s cycle_count got=%0d exp=%0d", e.name, cycle_count, e.cyc);
            end
            n_chk++;
            if (instret_count !== e.ret) begin
                n_fail++;
                $display("FAIL %s instret_count got=%0d exp=%0d", e.name, instret_count, e.ret);
            end
        end
    end

    initial begin
        reset = 1'b1; run = 1'b1; bus.opcode = '0; bus.zero = 1'b0;
        @(posedge clk); #1;
        // reset held with run high, then released
        cyc(T_IDLE, 1, 1, OP_R, 0);
        cyc(T_IDLE, 1, 1, OP_R, 0);
        cyc(T_IDLE, 0, 1, OP_R, 0);
        // R-type: 4 cycles
        cyc(T_FETCH, 0, 1, OP_R, 0);
        cyc(T_DECODE, 0, 1, OP_R, 0);
        cyc(T_EXEC_R, 0, 1, OP_R, 0);
        cyc(T_ALU_WB, 0, 1, OP_R, 0);
        // ld (5) then sd (4) back to back
        cyc(T_FETCH, 0, 1, OP_LD, 0);
        cyc(T_DECODE, 0, 1, OP_LD, 0);
        cyc(T_MEM_ADDR, 0, 1, OP_LD, 0);
        cyc(T_MEM_RD, 0, 1, OP_LD, 0);
        cyc(T_MEM_WB, 0, 1, OP_LD, 0);
        cyc(T_FETCH, 0, 1, OP_SD, 0);
        cyc(T_DECODE, 0, 1, OP_SD, 0);
        cyc(T_MEM_ADDR, 0, 1, OP_SD, 0);
        cyc(T_MEM_WR, 0, 1, OP_SD, 0);
        // beq not taken (zero high outside BRANCH must not leak), then taken
        cyc(T_FETCH, 0, 1, OP_BR, 1);
        cyc(T_DECODE, 0, 1, OP_BR, 1);
        cyc(T_BRANCH, 0, 1, OP_BR, 0);
        cyc(T_FETCH, 0, 1, OP_BR, 0);
        cyc(T_DECODE, 0, 1, OP_BR, 0);
        cyc(T_BRANCH, 0, 1, OP_BR, 1);
        // I-type with run dropped during EXEC_I: completes, then idles
        cyc(T_FETCH, 0, 1, OP_I, 0);
        cyc(T_DECODE, 0, 1, OP_I, 0);
        cyc(T_EXEC_I, 0, 0, OP_I, 0);
        cyc(T_ALU_WB, 0, 0, OP_I, 0);
        cyc(T_IDLE, 0, 0, OP_I, 0);
        cyc(T_IDLE, 0, 1, OP_LD, 0);
        // ld aborted by reset in MEM_RD (reset lands 1ns into that cycle)
        cyc(T_FETCH, 0, 1, OP_LD, 0);
        cyc(T_DECODE, 0, 1, OP_LD, 0);
        cyc(T_MEM_ADDR, 0, 1, OP_LD, 0);
        cyc(T_IDLE, 1, 1, OP_LD, 0);
        cyc(T_IDLE, 0, 0, OP_LD, 0);
        cyc(T_IDLE, 0, 1, OP_I, 0);
        cyc(T_FETCH, 0, 1, OP_I, 0);
        cyc(T_DECODE, 0, 1, OP_I, 0);
        cyc(T_EXEC_I, 0, 1, OP_I, 0);
        cyc(T_ALU_WB, 0, 1, OP_BAD, 0);
        // illegal opcode: sticky trap, run ignored, counters frozen
        cyc(T_FETCH, 0, 1, OP_BAD, 0);
        cyc(T_DECODE, 0, 1, OP_BAD, 0);
        cyc(T_TRAP, 0, 0, OP_R, 0);
        cyc(T_TRAP, 0, 1, OP_R, 1);
        cyc(T_TRAP, 0, 0, OP_R, 0);
        cyc(T_TRAP, 0, 1, OP_R, 0);
        cyc(T_IDLE, 1, 0, OP_R, 0);
        cyc(T_IDLE, 0, 0, OP_R, 0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
